score_keeper: RTL and testbench
===============================

# score_keeper

Downstream consumer of the coin collection pulse and of the per-frame game tick. It converts coin pickups (with a combo multiplier) and distance travelled into points. Points go into a 6-digit BCD score that the HUD renderer displays directly. It also keeps a BCD high score across runs and flags a new record at game over.

## Interface
- `COIN_POINTS`, 50: base value of one coin.
- `COMBO_FRAMES`, 90: frames after a pickup during which the next pickup raises the multiplier.
- `MAX_MULT`, 4: multiplier ceiling.
- `DIST_FRAMES`, 30: frames per distance award.
- `clock`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high.
- `frame_done`  in  1: one-cycle pulse per video frame.
- `game_active`  in  1: level, high while a run is in progress.
- `game_start`  in  1: one-cycle pulse that begins a new run.
- `coin_collected`  in  1: level from the coin stage; it may be high for many cycles within a frame.
- `speed`  in  4: current scroll speed in px/frame.
- `score_bcd`  out  24: six BCD digits; [23:20] is the most significant.
- `high_bcd`  out  24: high score, six BCD digits.
- `multiplier`  out  3: current combo multiplier, 1..MAX_MULT.
- `busy`  out  1: high while pending points are non-zero.
- `new_high`  out  1: high once a finished run has beaten the previous high score.

## Operation
- **Frame event.** A frame event is `frame_done && game_active`. All awards are sampled only on this cycle. `coin_collected` outside a frame event is ignored, so one pickup is credited exactly once.
- **Combo.**
  - `combo_timer` (7 bits) decrements on every frame event while it is > 0.
  - On a coin at a frame event: if `combo_timer > 0`, then `multiplier <= min(multiplier+1, MAX_MULT)`; otherwise `multiplier <= 1`.
  - In both cases `combo_timer <= COMBO_FRAMES`.
  - The award is `COIN_POINTS * new multiplier`: 50, 100, 150 or 200.
- **Distance.**
  - `dist_cnt` counts frame events.
  - When `dist_cnt == DIST_FRAMES-1`, it wraps to 0 and awards `speed` points; an award of 0 is legal.
- **Pending counter.** Awards accumulate in a 12-bit binary `pending` counter.
  - Next value is `pending + coin_award + dist_award - drain`, saturating at 4095.
  - Coin and distance awards on the same frame event are both added.
- **Drain.**
  - Each cycle with `pending > 0` and `score_bcd != 999999`: increment `score_bcd` by 1 with BCD ripple carry (digit 9 → 0, carry to the next digit), and decrement `pending` by 1.
  - If `score_bcd == 999999`, `pending` is cleared to 0 and the score holds.
- **busy** equals `(pending != 0)`, registered.
- **Game over.**
  - A registered copy of `game_active` detects the 1→0 edge, which sets the `over_armed` flag.
  - While `over_armed` and `pending == 0`: if `score_bcd > high_bcd` (digit-wise unsigned compare, most significant digit first), then `high_bcd <= score_bcd` and `new_high <= 1`. `over_armed` clears in the same cycle.
  - The score therefore drains fully before the comparison is made.
- **game_start.** Clears `score_bcd`, `pending`, `dist_cnt`, `combo_timer`, `over_armed` and `new_high`, and sets `multiplier` to 1. `high_bcd` is kept.
- **Priority.** `reset` > `game_start` > frame-event awards and drain.
  - Awards arriving in the same cycle as `game_start` are discarded.
- **Reset.**
  - `score_bcd = 0`, `high_bcd = 0`, `multiplier = 1`, `busy = 0`, `new_high = 0`.
  - All internal counters are 0 and `over_armed = 0`.

## Timing
- An award sampled on frame-event cycle t appears in `pending` at t+1. The first score increment is visible at t+2.
- The score then rises by 1 per cycle. A 200-point coin completes at t+201; `busy` falls at t+201.
- `multiplier` updates at t+1 after the coin frame event.
- **High-score latency.** Game-over edge at cycle t (`game_active` low at t): `over_armed` is set at t+1. `high_bcd`/`new_high` update one cycle after the first cycle where `over_armed && pending == 0`.
- **Mid-operation events.**
  - `game_start` during a drain stops it immediately: the score reads 0 at the next cycle.
  - `reset` mid-drain behaves the same way and also clears `high_bcd`.
- Draining continues while `game_active` is low; only new awards require `game_active`.

## Test plan
- **Single coin.** After reset + `game_start`, `coin_collected` high across one frame event (`speed` = 0) → `multiplier` = 1; `score_bcd` = 000050 after 50 drain cycles; `busy` is high for exactly 50 cycles.
- **Combo.** Four coins on frame events 10 frames apart → awards 50, 100, 150, 200, total 000500, `multiplier` = 4. A fifth coin 91 frames after the fourth → `multiplier` = 1, total 000550.
- **Distance + simultaneous coin.** `speed` = 7, 30 frame events, with a coin on the 30th → `pending` receives 57 at once; `score_bcd` = 000057.
- **BCD carry / saturation.**
  - Preload the score to 000999 via awards, add 1 → 001000.
  - Drive the score to 999950 and award 200 → score holds at 999999, `pending` = 0, `busy` falls.
- **Game over / high score.**
  - Run 1 ends at 000300 → `high_bcd` = 000300, `new_high` = 1.
  - `game_start` → `new_high` = 0, score = 0.
  - Run 2 ends at 000250 → `high_bcd` stays 000300, `new_high` stays 0.
- **Abort mid-drain.** Coin award of 200, then `game_start` 20 cycles later → score = 000000 next cycle, `pending` = 0, `multiplier` = 1, `high_bcd` unchanged.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: turns coin pickups (with combo multiplier) and distance
// into a 6-digit BCD score, and keeps a BCD high score across runs.
module score_keeper #(
    parameter int COIN_POINTS  = 50,
    parameter int COMBO_FRAMES = 90,
    parameter int MAX_MULT     = 4,
    parameter int DIST_FRAMES  = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_done,
    input  logic        game_active,
    input  logic        game_start,
    input  logic        coin_collected,
    input  logic [3:0]  speed,
    output logic [23:0] score_bcd,
    output logic [23:0] high_bcd,
    output logic [2:0]  multiplier,
    output logic        busy,
    output logic        new_high
);

    localparam int DW = (DIST_FRAMES > 1) ? $clog2(DIST_FRAMES) : 1;

    localparam logic [DW-1:0] DIST_LAST = DW'(DIST_FRAMES - 1);
    localparam logic [6:0]    COMBO_LD  = 7'(COMBO_FRAMES);
    localparam logic [2:0]    MULT_MAX  = 3'(MAX_MULT);
    localparam logic [13:0]   COIN_W    = 14'(COIN_POINTS);
    localparam logic [13:0]   PEND_MAX  = 14'd4095;
    localparam logic [23:0]   SCORE_MAX = 24'h999999;

    // Registers
    logic [23:0]   r_score;
    logic [23:0]   r_high;
    logic [2:0]    r_mult;
    logic [6:0]    r_combo_timer;
    logic [DW-1:0] r_dist_cnt;
    logic [11:0]   r_pending;
    logic          r_busy;
    logic          r_new_high;
    logic          r_active_d;
    logic          r_over_armed;

    // Combinational signals
    logic          w_frame_evt;
    logic          w_coin_evt;
    logic          w_dist_wrap;
    logic [2:0]    w_mult_next;
    logic [13:0]   w_coin_award;
    logic [13:0]   w_dist_award;
    logic          w_score_full;
    logic          w_drain;
    logic [13:0]   w_pend_sum;
    logic [11:0]   w_pend_next;
    logic [23:0]   w_score_inc;
    logic [23:0]   w_score_next;
    logic          w_over_edge;
    logic          w_over_fire;
    logic          w_beat;

    // Add one to a six-digit BCD value with ripple carry across digits.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    // Digit-wise unsigned compare, most significant digit first.
    function automatic logic bcd_gt(input logic [23:0] a,
                                    input logic [23:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            if (!done && (a[i*4 +: 4] != b[i*4 +: 4])) begin
                gt   = (a[i*4 +: 4] > b[i*4 +: 4]);
                done = 1'b1;
            end
        end
        return gt;
    endfunction

    // Awards are only sampled on a frame of an active run.
    assign w_frame_evt = frame_done & game_active;
    assign w_coin_evt  = w_frame_evt & coin_collected;
    assign w_dist_wrap = w_frame_evt & (r_dist_cnt == DIST_LAST);

    // Multiplier a coin would get: grows inside the combo window, else 1.
    always_comb begin
        w_mult_next = r_mult;
        if (r_combo_timer == 7'd0) begin
            w_mult_next = 3'd1;
        end else if (r_mult < MULT_MAX) begin
            w_mult_next = r_mult + 3'd1;
        end
    end

    assign w_coin_award = w_coin_evt ? (COIN_W * {11'd0, w_mult_next})
                                     : 14'd0;
    assign w_dist_award = w_dist_wrap ? {10'd0, speed} : 14'd0;

    // Drain one point per cycle unless the score is already pegged.
    assign w_score_full = (r_score == SCORE_MAX);
    assign w_drain      = (r_pending != 12'd0) && !w_score_full;

    assign w_pend_sum = {2'b00, r_pending} + w_coin_award
                      + w_dist_award - {13'd0, w_drain};

    // Saturate pending at 4095; a pegged score swallows everything.
    always_comb begin
        w_pend_next = w_pend_sum[11:0];
        if (w_score_full) begin
            w_pend_next = 12'd0;
        end else if (w_pend_sum > PEND_MAX) begin
            w_pend_next = 12'd4095;
        end
    end

    assign w_score_inc  = bcd_inc(r_score);
    assign w_score_next = w_drain ? w_score_inc : r_score;

    // Game over is the falling edge of game_active; compare once drained.
    assign w_over_edge = r_active_d & ~game_active;
    assign w_over_fire = r_over_armed & (r_pending == 12'd0);
    assign w_beat      = w_over_fire & bcd_gt(r_score, r_high);

    // Combo timer and multiplier, updated on frame events.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_combo_timer <= 7'd0;
            r_mult        <= 3'd1;
        end else if (game_start) begin
            r_combo_timer <= 7'd0;
            r_mult        <= 3'd1;
        end else if (w_frame_evt) begin
            if (coin_collected) begin
                r_combo_timer <= COMBO_LD;
                r_mult        <= w_mult_next;
            end else if (r_combo_timer != 7'd0) begin
                r_combo_timer <= r_combo_timer - 7'd1;
            end
        end
    end

    // Distance frame counter, wraps once per distance award.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dist_cnt <= '0;
        end else if (game_start) begin
            r_dist_cnt <= '0;
        end else if (w_frame_evt) begin
            if (r_dist_cnt == DIST_LAST) begin
                r_dist_cnt <= '0;
            end else begin
                r_dist_cnt <= r_dist_cnt + 1'b1;
            end
        end
    end

    // Pending points accumulator and its busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= 12'd0;
            r_busy    <= 1'b0;
        end else if (game_start) begin
            r_pending <= 12'd0;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_busy    <= (w_pend_next != 12'd0);
        end
    end

    // BCD score register, fed one point per drain cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_score <= 24'h000000;
        end else if (game_start) begin
            r_score <= 24'h000000;
        end else begin
            r_score <= w_score_next;
        end
    end

    // Game-over detection and high-score update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_active_d   <= 1'b0;
            r_over_armed <= 1'b0;
            r_high       <= 24'h000000;
            r_new_high   <= 1'b0;
        end else begin
            r_active_d <= game_active;
            if (game_start) begin
                r_over_armed <= 1'b0;
                r_new_high   <= 1'b0;
            end else begin
                if (w_beat) begin
                    r_high     <= r_score;
                    r_new_high <= 1'b1;
                end
                if (w_over_edge) begin
                    r_over_armed <= 1'b1;
                end else if (w_over_fire) begin
                    r_over_armed <= 1'b0;
                end
            end
        end
    end

    assign score_bcd  = r_score;
    assign high_bcd   = r_high;
    assign multiplier = r_mult;
    assign busy       = r_busy;
    assign new_high   = r_new_high;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scenarios plus random traffic, all checked
// every cycle against an integer-arithmetic model of the scoring rules.
module tb_score_keeper;

    logic        clock;
    logic        reset;
    logic        frame_done;
    logic        game_active;
    logic        game_start;
    logic        coin_collected;
    logic [3:0]  speed;
    logic [23:0] score_bcd;
    logic [23:0] high_bcd;
    logic [2:0]  multiplier;
    logic        busy;
    logic        new_high;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 0;

    bit preload  = 0;
    int pval     = 0;

    // Model state: plain integers.
    int m_score, m_high, m_pend, m_mult, m_timer, m_dist;
    bit m_armed, m_nh, m_act_d;

    score_keeper dut (
        .clock          (clock),
        .reset          (reset),
        .frame_done     (frame_done),
        .game_active    (game_active),
        .game_start     (game_start),
        .coin_collected (coin_collected),
        .speed          (speed),
        .score_bcd      (score_bcd),
        .high_bcd       (high_bcd),
        .multiplier     (multiplier),
        .busy           (busy),
        .new_high       (new_high)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int d;
        r = '0;
        d = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [23:0] act,
                       input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model, one step per rising edge.
    always @(posedge clock) begin : model
        int p;
        int aw;
        int d;
        if (reset) begin
            m_score = 0; m_high = 0; m_pend = 0; m_mult = 1;
            m_timer = 0; m_dist = 0;
            m_armed = 0; m_nh = 0; m_act_d = 0;
        end else begin
            p = m_pend;
            if (game_start) begin
                m_armed = 0;
                m_nh    = 0;
            end else begin
                if (m_armed && p == 0 && m_score > m_high) begin
                    m_high = m_score;
                    m_nh   = 1;
                end
                if (m_act_d && !game_active) m_armed = 1;
                else if (m_armed && p == 0) m_armed = 0;
            end
            m_act_d = game_active;
            if (game_start) begin
                m_score = 0; m_pend = 0; m_dist = 0;
                m_timer = 0; m_mult = 1;
            end else begin
                aw = 0;
                if (frame_done && game_active) begin
                    if (coin_collected) begin
                        if (m_timer > 0)
                            m_mult = (m_mult + 1 > 4) ? 4 : m_mult + 1;
                        else
                            m_mult = 1;
                        m_timer = 90;
                        aw += 50 * m_mult;
                    end else if (m_timer > 0) begin
                        m_timer--;
                    end
                    if (m_dist == 29) begin
                        m_dist = 0;
                        aw += int'(speed);
                    end else begin
                        m_dist++;
                    end
                end
                if (m_score == 999999) begin
                    m_pend = 0;
                end else begin
                    d = (p > 0) ? 1 : 0;
                    m_score += d;
                    m_pend = p + aw - d;
                    if (m_pend > 4095) m_pend = 4095;
                end
                if (preload) m_score = pval;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("score", score_bcd, to_bcd(m_score));
            chk("high", high_bcd, to_bcd(m_high));
            chk("mult", {21'd0, multiplier}, 24'(m_mult));
            chk("busy", {23'd0, busy}, {23'd0, m_pend != 0});
            chk("new_high", {23'd0, new_high}, {23'd0, m_nh});
        end
    end

    task automatic start_run();
        @(negedge clock);
        game_start = 1;
        @(negedge clock);
        game_start = 0;
    endtask

    task automatic frame(input bit coin, input logic [3:0] spd);
        @(negedge clock);
        frame_done     = 1;
        coin_collected = coin;
        speed          = spd;
        @(negedge clock);
        frame_done     = 0;
        coin_collected = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 6000) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", {23'd0, busy}, 24'd0);
    endtask

    task automatic count_busy(output int n);
        int k;
        n = busy ? 1 : 0;
        k = 0;
        while (busy && k < 6000) begin
            @(negedge clock);
            if (busy) n++;
            k++;
        end
    endtask

    task automatic do_preload(input logic [23:0] v, input int iv);
        @(negedge clock);
        preload = 1;
        pval    = iv;
        force dut.w_score_next = v;
        @(posedge clock);
        #1;
        release dut.w_score_next;
        preload = 0;
    endtask

    initial begin : stim
        int n;
        reset = 1; frame_done = 0; game_active = 0;
        game_start = 0; coin_collected = 0; speed = 0;
        repeat (3) @(negedge clock);
        chk_en = 1;
        reset  = 0;
        @(negedge clock);
        chk("rst_score", score_bcd, 24'h000000);
        chk("rst_high", high_bcd, 24'h000000);
        chk("rst_mult", {21'd0, multiplier}, 24'd1);
        chk("rst_busy", {23'd0, busy}, 24'd0);
        chk("rst_nh", {23'd0, new_high}, 24'd0);

        // Single coin.
        game_active = 1;
        start_run();
        frame(1, 0);
        chk("one_mult", {21'd0, multiplier}, 24'd1);
        count_busy(n);
        chk("one_busy_len", 24'(n), 24'd50);
        chk("one_score", score_bcd, 24'h000050);

        // Combo: four coins ten frames apart, then one after expiry.
        start_run();
        for (int c = 0; c < 4; c++) begin
            frame(1, 0);
            if (c < 3) repeat (9) frame(0, 0);
        end
        chk("combo_mult4", {21'd0, multiplier}, 24'd4);
        wait_idle();
        chk("combo_500", score_bcd, 24'h000500);
        repeat (90) frame(0, 0);
        frame(1, 0);
        chk("combo_mult1", {21'd0, multiplier}, 24'd1);
        wait_idle();
        chk("combo_550", score_bcd, 24'h000550);

        // Distance with simultaneous coin.
        start_run();
        repeat (29) frame(0, 7);
        frame(1, 7);
        count_busy(n);
        chk("dist_busy_len", 24'(n), 24'd57);
        chk("dist_57", score_bcd, 24'h000057);

        // BCD carry: build 999 from awards, then add one.
        start_run();
        for (int f = 1; f <= 120; f++)
            frame((f <= 6) || (f == 100), (f == 120) ? 4'd4 : 4'd15);
        wait_idle();
        chk("carry_999", score_bcd, 24'h000999);
        repeat (30) frame(0, 1);
        wait_idle();
        chk("carry_1000", score_bcd, 24'h001000);

        // Saturation near 999999.
        start_run();
        do_preload(24'h999950, 999950);
        chk("sat_preload", score_bcd, 24'h999950);
        repeat (4) frame(1, 0);
        wait_idle();
        chk("sat_score", score_bcd, 24'h999999);
        repeat (5) @(negedge clock);
        chk("sat_hold", score_bcd, 24'h999999);
        chk("sat_busy", {23'd0, busy}, 24'd0);

        // Run 1 ends at 300.
        start_run();
        repeat (3) frame(1, 0);
        @(negedge clock);
        game_active = 0;
        wait_idle();
        repeat (4) @(negedge clock);
        chk("run1_high", high_bcd, 24'h000300);
        chk("run1_nh", {23'd0, new_high}, 24'd1);
        game_active = 1;
        start_run();
        chk("run2_nh_clr", {23'd0, new_high}, 24'd0);
        chk("run2_score0", score_bcd, 24'h000000);

        // Run 2 ends at 250.
        for (int f = 1; f <= 184; f++)
            frame((f == 1) || (f == 2) || (f == 93) || (f == 184), 0);
        @(negedge clock);
        game_active = 0;
        wait_idle();
        repeat (4) @(negedge clock);
        chk("run2_score", score_bcd, 24'h000250);
        chk("run2_high", high_bcd, 24'h000300);
        chk("run2_nh", {23'd0, new_high}, 24'd0);

        // Abort mid-drain with game_start.
        game_active = 1;
        start_run();
        repeat (4) frame(1, 0);
        repeat (19) @(negedge clock);
        start_run();
        chk("abort_score", score_bcd, 24'h000000);
        chk("abort_busy", {23'd0, busy}, 24'd0);
        chk("abort_mult", {21'd0, multiplier}, 24'd1);
        chk("abort_high", high_bcd, 24'h000300);

        // Reset mid-drain.
        repeat (2) frame(1, 0);
        repeat (10) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("rmid_score", score_bcd, 24'h000000);
        chk("rmid_high", high_bcd, 24'h000000);

        // Random traffic.
        game_active = 1;
        start_run();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            if (((i / 250) % 2) == 1)
                frame_done = 1;
            else
                frame_done = ($urandom_range(2) == 0);
            coin_collected = ($urandom_range(1) == 1);
            speed          = 4'($urandom_range(15));
            if ($urandom_range(150) == 0) game_active = ~game_active;
            game_start = ($urandom_range(500) == 0);
            reset      = ($urandom_range(1500) == 0);
        end
        @(negedge clock);
        frame_done = 0; coin_collected = 0; game_start = 0;
        reset = 0; game_active = 0;
        wait_idle();
        repeat (5) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
